// File: rtl/reorder_buffer_pkg.sv
// Shared ROB, exception and register-file constants plus the ROB entry layout.
package reorder_buffer_pkg;

    localparam int DEF_ROB_DEPTH  = 32;
    localparam int DEF_ROB_ADDR_W = 5;
    localparam int EXC_TYPE_W     = 5;
    localparam int RF_ADDR_W      = 5;

    localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_NULL = '0;

    typedef struct packed {
        logic                  reg_write_add;
        logic                  reg_write_en;
        logic [RF_ADDR_W-1:0]  reg_write_addr;
        logic [31:0]           reg_write_data;
        logic                  reg_write_lo_en;
        logic [31:0]           reg_write_lo_data;
        logic [EXC_TYPE_W-1:0] exception_type;
        logic                  is_delayslot;
        logic [31:0]           pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, out-of-order writeback, commit from head.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_DEPTH  = DEF_ROB_DEPTH,
    parameter int ROB_ADDR_W = DEF_ROB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  rob_write_en,
    output logic                  rob_can_write,
    output logic [ROB_ADDR_W-1:0] rob_write_addr,
    input  logic                  i_reg_write_add,
    input  logic                  i_reg_write_en,
    input  logic [RF_ADDR_W-1:0]  i_reg_write_addr,
    input  logic                  i_reg_write_lo_en,
    input  logic [EXC_TYPE_W-1:0] i_exception_type,
    input  logic                  i_is_delayslot,
    input  logic [31:0]           i_pc,

    input  logic                  wb_en,
    input  logic [ROB_ADDR_W-1:0] wb_addr,
    input  logic [31:0]           wb_data,
    input  logic [31:0]           wb_lo_data,
    input  logic [EXC_TYPE_W-1:0] wb_exception_type,

    input  logic                  rob_commit_en,
    output logic                  rob_can_commit,
    output logic                  o_reg_write_add,
    output logic                  o_reg_write_en,
    output logic [RF_ADDR_W-1:0]  o_reg_write_addr,
    output logic [31:0]           o_reg_write_data,
    output logic                  o_reg_write_lo_en,
    output logic [31:0]           o_reg_write_lo_data,
    output logic [EXC_TYPE_W-1:0] o_exception_type,
    output logic                  o_is_delayslot,
    output logic [31:0]           o_pc
);

    rob_entry_t [ROB_DEPTH-1:0] r_entry;
    logic [ROB_DEPTH-1:0]       r_valid;
    logic [ROB_DEPTH-1:0]       r_done;
    logic [ROB_ADDR_W-1:0]      r_head;
    logic [ROB_ADDR_W-1:0]      r_tail;
    logic [ROB_ADDR_W:0]        r_count;

    logic       w_write;
    logic       w_commit;
    rob_entry_t w_head_entry;

    assign rob_can_write  = (r_count != (ROB_ADDR_W+1)'(ROB_DEPTH));
    assign rob_write_addr = r_tail;
    assign w_head_entry   = r_entry[r_head];
    assign rob_can_commit = r_valid[r_head] && r_done[r_head];

    assign w_write  = rob_write_en && rob_can_write;
    assign w_commit = rob_commit_en && rob_can_commit;

    assign o_reg_write_add     = w_head_entry.reg_write_add;
    assign o_reg_write_en      = w_head_entry.reg_write_en;
    assign o_reg_write_addr    = w_head_entry.reg_write_addr;
    assign o_reg_write_data    = w_head_entry.reg_write_data;
    assign o_reg_write_lo_en   = w_head_entry.reg_write_lo_en;
    assign o_reg_write_lo_data = w_head_entry.reg_write_lo_data;
    assign o_exception_type    = w_head_entry.exception_type;
    assign o_is_delayslot      = w_head_entry.is_delayslot;
    assign o_pc                = w_head_entry.pc;

    // Tail and head only alias when empty (no commit) or full (no write),
    // so allocate, writeback and commit never collide on one index.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_entry <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_write) begin
                r_entry[r_tail] <= '{
                    reg_write_add:     i_reg_write_add,
                    reg_write_en:      i_reg_write_en,
                    reg_write_addr:    i_reg_write_addr,
                    reg_write_data:    '0,
                    reg_write_lo_en:   i_reg_write_lo_en,
                    reg_write_lo_data: '0,
                    exception_type:    i_exception_type,
                    is_delayslot:      i_is_delayslot,
                    pc:                i_pc
                };
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= (i_exception_type != EXC_TYPE_NULL);
                r_tail          <= r_tail + ROB_ADDR_W'(1);
            end

            if (wb_en && r_valid[wb_addr]) begin
                r_entry[wb_addr].reg_write_data    <= wb_data;
                r_entry[wb_addr].reg_write_lo_data <= wb_lo_data;
                r_done[wb_addr]                    <= 1'b1;
                // An exception raised at allocation survives a clean writeback.
                if (wb_exception_type != EXC_TYPE_NULL)
                    r_entry[wb_addr].exception_type <= wb_exception_type;
            end

            if (w_commit) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + ROB_ADDR_W'(1);
            end

            case ({w_write, w_commit})
                2'b10:   r_count <= r_count + (ROB_ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ROB_ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed stimulus with a commit-side scoreboard for reorder_buffer.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, flush;
    logic                  rob_write_en, rob_can_write;
    logic [AW-1:0]         rob_write_addr;
    logic                  i_reg_write_add, i_reg_write_en, i_reg_write_lo_en, i_is_delayslot;
    logic [RF_ADDR_W-1:0]  i_reg_write_addr;
    logic [EXC_TYPE_W-1:0] i_exception_type;
    logic [31:0]           i_pc;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [31:0]           wb_data, wb_lo_data;
    logic [EXC_TYPE_W-1:0] wb_exception_type;
    logic                  rob_commit_en, rob_can_commit;
    logic                  o_reg_write_add, o_reg_write_en, o_reg_write_lo_en, o_is_delayslot;
    logic [RF_ADDR_W-1:0]  o_reg_write_addr;
    logic [31:0]           o_reg_write_data, o_reg_write_lo_data, o_pc;
    logic [EXC_TYPE_W-1:0] o_exception_type;

    reorder_buffer #(.ROB_DEPTH(DEPTH), .ROB_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rob_write_en(rob_write_en), .rob_can_write(rob_can_write), .rob_write_addr(rob_write_addr),
        .i_reg_write_add(i_reg_write_add), .i_reg_write_en(i_reg_write_en),
        .i_reg_write_addr(i_reg_write_addr), .i_reg_write_lo_en(i_reg_write_lo_en),
        .i_exception_type(i_exception_type), .i_is_delayslot(i_is_delayslot), .i_pc(i_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_lo_data(wb_lo_data),
        .wb_exception_type(wb_exception_type),
        .rob_commit_en(rob_commit_en), .rob_can_commit(rob_can_commit),
        .o_reg_write_add(o_reg_write_add), .o_reg_write_en(o_reg_write_en),
        .o_reg_write_addr(o_reg_write_addr), .o_reg_write_data(o_reg_write_data),
        .o_reg_write_lo_en(o_reg_write_lo_en), .o_reg_write_lo_data(o_reg_write_lo_data),
        .o_exception_type(o_exception_type), .o_is_delayslot(o_is_delayslot), .o_pc(o_pc)
    );

    typedef struct {
        logic [31:0]           pc;
        logic [EXC_TYPE_W-1:0] exc;
        logic [31:0]           data;
        logic [31:0]           lo;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted commit must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && rob_commit_en === 1'b1 && rob_can_commit === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL commit_unexpected: got pc 0x%0h, expected no commit", o_pc);
                end else begin
                    e = sb.pop_front();
                    chk("commit_pc",      o_pc, e.pc);
                    chk("commit_exc",     32'(o_exception_type), 32'(e.exc));
                    chk("commit_data",    o_reg_write_data, e.data);
                    chk("commit_lo",      o_reg_write_lo_data, e.lo);
                    chk("commit_rfaddr",  32'(o_reg_write_addr), 32'(e.pc[6:2]));
                    chk("commit_flags",
                        32'({o_reg_write_en, o_reg_write_add, o_reg_write_lo_en, o_is_delayslot}),
                        32'({e.pc[2], e.pc[3], e.pc[4], e.pc[5]}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
        rob_write_en  = 1'b0;
        wb_en         = 1'b0;
        rob_commit_en = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [EXC_TYPE_W-1:0] exc);
        rob_write_en      = 1'b1;
        i_pc              = pc;
        i_exception_type  = exc;
        i_reg_write_addr  = pc[6:2];
        i_reg_write_en    = pc[2];
        i_reg_write_add   = pc[3];
        i_reg_write_lo_en = pc[4];
        i_is_delayslot    = pc[5];
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [EXC_TYPE_W-1:0] exc,
                            input logic [31:0] data, input logic [31:0] lo);
        exp_t e;
        e.pc = pc; e.exc = exc; e.data = data; e.lo = lo;
        sb.push_back(e);
    endtask

    task automatic set_wb(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [31:0] lo, input logic [EXC_TYPE_W-1:0] exc);
        wb_en             = 1'b1;
        wb_addr           = addr;
        wb_data           = data;
        wb_lo_data        = lo;
        wb_exception_type = exc;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        sb.delete();
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b0; flush = 1'b0; rob_write_en = 1'b0; wb_en = 1'b0; rob_commit_en = 1'b0;
        i_reg_write_add = 1'b0; i_reg_write_en = 1'b0; i_reg_write_addr = '0;
        i_reg_write_lo_en = 1'b0; i_exception_type = '0; i_is_delayslot = 1'b0; i_pc = '0;
        wb_addr = '0; wb_data = '0; wb_lo_data = '0; wb_exception_type = '0;
        step();
        pulse_reset();

        chk("rst_can_write",  32'(rob_can_write), 32'd1);
        chk("rst_write_addr", 32'(rob_write_addr), 32'd0);
        chk("rst_can_commit", 32'(rob_can_commit), 32'd0);
        chk("rst_pc",         o_pc, 32'd0);
        chk("rst_data",       o_reg_write_data | o_reg_write_lo_data, 32'd0);
        chk("rst_fields",     32'({o_reg_write_add, o_reg_write_en, o_reg_write_addr,
                                  o_reg_write_lo_en, o_exception_type, o_is_delayslot}), 32'd0);

        // Three allocations, out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) begin
            chk("alloc_addr", 32'(rob_write_addr), 32'(i));
            pc = 32'h100 + 32'(4 * i);
            set_alloc(pc, '0);
            step();
        end
        push_exp(32'h100, '0, 32'hAA, 32'hA0);
        push_exp(32'h104, '0, 32'h11, 32'h22);
        push_exp(32'h108, '0, 32'h33, 32'h44);
        chk("three_write_addr", 32'(rob_write_addr), 32'd3);
        chk("three_can_commit", 32'(rob_can_commit), 32'd0);
        set_wb(5'd1, 32'h11, 32'h22, '0);
        step();
        chk("wb1_can_commit", 32'(rob_can_commit), 32'd0);
        set_wb(5'd0, 32'hAA, 32'hA0, '0);
        rob_commit_en = 1'b1;
        step();
        chk("wb0_can_commit", 32'(rob_can_commit), 32'd1);
        chk("wb0_head_pc", o_pc, 32'h100);
        rob_commit_en = 1'b1;
        step();
        chk("c0_can_commit", 32'(rob_can_commit), 32'd1);
        rob_commit_en = 1'b1;
        step();
        chk("c1_can_commit", 32'(rob_can_commit), 32'd0);
        set_wb(5'd2, 32'h33, 32'h44, '0);
        step();
        rob_commit_en = 1'b1;
        step();
        chk("drain_can_commit", 32'(rob_can_commit), 32'd0);
        chk("drain_write_addr", 32'(rob_write_addr), 32'd3);

        // Reset mid-operation discards in-flight entries.
        set_alloc(32'hF00, '0);
        step();
        set_alloc(32'hF04, '0);
        step();
        pulse_reset();
        chk("midrst_write_addr", 32'(rob_write_addr), 32'd0);
        chk("midrst_can_commit", 32'(rob_can_commit), 32'd0);
        chk("midrst_pc", o_pc, 32'd0);

        // Fill to full, rejected writes, write+commit while full.
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_addr", 32'(rob_write_addr), 32'(i));
            pc = 32'h1000 + 32'(4 * i);
            set_alloc(pc, '0);
            push_exp(pc, '0, 32'h5000 + 32'(i), 32'(i));
            step();
        end
        chk("full_can_write", 32'(rob_can_write), 32'd0);
        chk("full_write_addr", 32'(rob_write_addr), 32'd0);
        set_alloc(32'hDEAD0, '0);
        step();
        chk("full_reject_can_write", 32'(rob_can_write), 32'd0);
        set_wb(5'd0, 32'h5000, 32'd0, '0);
        step();
        set_alloc(32'hBAD00, '0);
        rob_commit_en = 1'b1;
        step();
        chk("full_wc_can_write", 32'(rob_can_write), 32'd1);
        chk("full_wc_write_addr", 32'(rob_write_addr), 32'd0);
        set_alloc(32'h2000, '0);
        push_exp(32'h2000, '0, 32'h6000, 32'h7);
        step();
        chk("refill_can_write", 32'(rob_can_write), 32'd0);
        for (int i = 1; i < DEPTH; i++) begin
            set_wb(5'(i), 32'h5000 + 32'(i), 32'(i), '0);
            rob_commit_en = 1'b1;
            step();
        end
        set_wb(5'd0, 32'h6000, 32'h7, '0);
        rob_commit_en = 1'b1;
        step();
        rob_commit_en = 1'b1;
        step();
        chk("full_drain_can_commit", 32'(rob_can_commit), 32'd0);
        chk("full_drain_write_addr", 32'(rob_write_addr), 32'd1);

        // Wrap-around: allocate and commit the previous entry in the same cycle.
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            chk("wrap_addr", 32'(rob_write_addr), 32'(i % DEPTH));
            pc = 32'h4000 + 32'(4 * i);
            set_alloc(pc, '0);
            push_exp(pc, '0, 32'h9000 + 32'(i), 32'(i));
            if (i > 0) rob_commit_en = 1'b1;
            step();
            set_wb(5'(i % DEPTH), 32'h9000 + 32'(i), 32'(i), '0);
            step();
        end
        rob_commit_en = 1'b1;
        step();
        chk("wrap_can_commit", 32'(rob_can_commit), 32'd0);
        chk("wrap_write_addr", 32'(rob_write_addr), 32'd8);

        // Exceptions: done at allocation, merge on writeback.
        set_alloc(32'h300, 5'd5);
        push_exp(32'h300, 5'd5, 32'd0, 32'd0);
        step();
        chk("exc_can_commit", 32'(rob_can_commit), 32'd1);
        chk("exc_head_type", 32'(o_exception_type), 32'd5);
        rob_commit_en = 1'b1;
        step();
        set_alloc(32'h304, '0);
        push_exp(32'h304, 5'd3, 32'h77, 32'h88);
        step();
        set_wb(5'd9, 32'h77, 32'h88, 5'd3);
        step();
        chk("wbexc_can_commit", 32'(rob_can_commit), 32'd1);
        rob_commit_en = 1'b1;
        step();
        set_alloc(32'h308, 5'd5);
        push_exp(32'h308, 5'd5, 32'h55, 32'h66);
        step();
        set_wb(5'd10, 32'h55, 32'h66, '0);
        step();
        rob_commit_en = 1'b1;
        step();
        chk("exc_write_addr", 32'(rob_write_addr), 32'd11);

        // Flush beats a concurrent write and writeback.
        for (int i = 0; i < 5; i++) begin
            pc = 32'h500 + 32'(4 * i);
            set_alloc(pc, '0);
            step();
        end
        flush = 1'b1;
        set_alloc(32'h600, '0);
        set_wb(5'd11, 32'h1234, 32'h5678, '0);
        step();
        chk("flush_write_addr", 32'(rob_write_addr), 32'd0);
        chk("flush_can_commit", 32'(rob_can_commit), 32'd0);
        chk("flush_can_write", 32'(rob_can_write), 32'd1);
        rob_commit_en = 1'b1;
        step();
        chk("flush_idle_write_addr", 32'(rob_write_addr), 32'd0);
        set_alloc(32'h700, 5'd4);
        push_exp(32'h700, 5'd4, 32'd0, 32'd0);
        step();
        chk("postflush_can_commit", 32'(rob_can_commit), 32'd1);
        rob_commit_en = 1'b1;
        step();
        chk("postflush_empty", 32'(rob_can_commit), 32'd0);

        step();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 32, number of entries (power of two).
REQ-002 SHALL have parameter ROB_ADDR_W, default 5, log2(ROB_DEPTH); equals width of ROB_ADDR_BUS.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  in  1  discard all entries (exception/mispredict redirect).
REQ-006 SHALL have ports rob_write_en in 1 allocate; rob_can_write out 1 not full; rob_write_addr out ROB_ADDR_W tail index.
REQ-007 SHALL have write-data inputs: reg_write_add 1, reg_write_en 1, reg_write_addr 5, reg_write_lo_en 1, exception_type EXC_TYPE_W, is_delayslot 1, pc 32.
REQ-008 SHALL have writeback inputs: wb_en 1, wb_addr ROB_ADDR_W, wb_data 32, wb_lo_data 32, wb_exception_type EXC_TYPE_W.
REQ-009 SHALL have ports rob_commit_en in 1 retire head; rob_can_commit out 1 head valid and done.
REQ-010 SHALL have commit outputs mirroring head entry: reg_write_add, reg_write_en, reg_write_addr, reg_write_data 32, reg_write_lo_en, reg_write_lo_data 32, exception_type, is_delayslot, pc.

Function
REQ-011 SHALL be a circular buffer: head (oldest), tail (next free), count 0..ROB_DEPTH, ROB_ADDR_W-bit pointers wrapping modulo ROB_DEPTH.
REQ-012 SHALL drive rob_can_write = (count != ROB_DEPTH), rob_write_addr = tail, combinationally from registered state.
REQ-013 SHALL, on rob_write_en && rob_can_write, store write-data into entry[tail], set valid, clear data fields, advance tail by 1 next cycle.
REQ-014 SHALL set done at allocation when exception_type != EXC_TYPE_NULL; otherwise done = 0.
REQ-015 SHALL ignore rob_write_en when full; no state change.
REQ-016 SHALL, on wb_en with entry[wb_addr] valid, write wb_data, wb_lo_data, set done; OR-merge: overwrite exception_type only if wb_exception_type != NULL.
REQ-017 SHALL ignore wb_en targeting an invalid entry.
REQ-018 SHALL drive rob_can_commit = valid[head] && done[head]; commit outputs = entry[head] fields, combinational, zero-latency.
REQ-019 SHALL, on rob_commit_en && rob_can_commit, clear valid[head], advance head by 1; rob_commit_en with rob_can_commit low SHALL be ignored.
REQ-020 SHALL, on simultaneous accepted write and commit, leave count unchanged, both pointers advance; when full, write is rejected even if commit occurs same cycle.
REQ-021 SHALL, on writeback to head in same cycle, expose new done only next cycle (commit uses pre-edge state).
REQ-022 SHALL give flush priority over write, writeback and commit: all valid cleared, head = tail = count = 0 next cycle.
REQ-023 SHALL make write-after-commit of the same index in one cycle impossible by construction (tail==head only when empty or full).

Reset
REQ-024 SHALL on rst low at clk edge clear all valid/done bits, head = tail = count = 0, entry fields 0.
REQ-025 SHALL after reset present rob_can_write=1, rob_write_addr=0, rob_can_commit=0, all commit outputs 0.
REQ-026 SHALL treat reset mid-operation identically to flush, discarding in-flight entries; no output glitch beyond the combinational paths.

Structure
REQ-027 SHALL take ROB_DEPTH, ROB_ADDR_W, EXC_TYPE_W, EXC_TYPE_NULL, RF address width from shared rob/exception/regfile header constants.
REQ-028 SHALL be implemented as one module with an internal entry array; no sub-module; a pointer/count register block is optional inline.

Verification
REQ-029 SHALL cover: reset, write 3 entries (pc 0x100,0x104,0x108) -> write_addr 0,1,2, count 3, can_commit 0.
REQ-030 SHALL cover: writeback addr 1 then addr 0 data 0xAA -> can_commit rises cycle after addr-0 writeback; commits in order pc 0x100 then 0x104.
REQ-031 SHALL cover: fill 32 entries -> can_write 0; write+commit same cycle when full -> write rejected, count 31.
REQ-032 SHALL cover: wrap-around, 40 alloc/commit pairs -> write_addr sequence 0..31,0..7, no lost entry.
REQ-033 SHALL cover: allocate with exception_type != NULL -> can_commit 1 next cycle without writeback; exception_type at commit output.
REQ-034 SHALL cover: flush with 5 entries plus concurrent write and wb -> next cycle count 0, write_addr 0, can_commit 0.
